inst_mem_prog: RTL and testbench
================================

Name: inst_mem_prog

Overview:
- Parametrised successor to the fixed 256-byte, two-byte-instruction ROM.
- Byte-addressed instruction store with a run-time byte-stream programming port, so the FPGA image can be loaded without resynthesis.
- Fetch port uses a req/ready/valid handshake and assembles INST_BYTES bytes big-endian, one byte per cycle, which models a single-read-port RAM.
- Sits between the PC register and the decoder; the programming port is driven by the board loader.

Parameters:
ADDR_W, 8, byte-address width; depth = 2**ADDR_W bytes
INST_BYTES, 2, bytes per instruction (>=1); inst width = 8*INST_BYTES
INIT_ZERO, 1, 1 = every byte is 0 (NOP) at time zero; 0 = contents undefined

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
prog_start  in  1  pulse: programming pointer returns to 0
prog_en  in  1  write prog_data at the pointer this cycle
prog_data  in  8  byte to write
prog_ptr  out  ADDR_W  next programming address
fetch_req  in  1  request a fetch at fetch_pc
fetch_pc  in  ADDR_W  byte address of the instruction's first (MSB) byte
fetch_ready  out  1  a fetch request is accepted this cycle
inst_valid  out  1  one-cycle pulse: inst holds a new instruction
inst  out  8*INST_BYTES  assembled instruction

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, prog_ptr=0, inst=0, inst_valid=0, byte counter=0.
  - Memory contents are NOT affected by rst.
- Storage: 2**ADDR_W x 8 array. All addresses are modulo 2**ADDR_W and wrap silently.
- Programming:
  - prog_start=1: prog_ptr<=0.
  - prog_en=1: mem[p]<=prog_data, prog_ptr<=p+1 (wraps).
  - p is 0 if prog_start=1 in the same cycle, otherwise it is prog_ptr.
  - A write becomes visible to any fetch read on a later cycle.
- fetch_ready = (state==IDLE) & ~prog_en (combinational).
- FSM:
  - IDLE: on fetch_req & fetch_ready, capture addr_q<=fetch_pc, clear k and the shift register, then go to READ.
  - READ: each cycle, shift<={shift[8*INST_BYTES-9:0], mem[addr_q+k]}, k<=k+1.
  - READ exit: when k==INST_BYTES-1, on the same edge inst<={shifted value}, inst_valid<=1, go to IDLE.
- Latency: request accepted at edge N -> inst_valid=1 during the cycle after edge N+INST_BYTES. With INST_BYTES=2, valid is seen 2 cycles after acceptance.
- Throughput: a new request can be accepted in the same cycle that inst_valid=1 is shown. Result: one instruction per INST_BYTES+1 cycles.
- Byte order: the byte at fetch_pc becomes inst[8*INST_BYTES-1 -: 8] (MSB). This matches the existing opcode-byte-first encoding.
- Output hold: inst holds its last value between valid pulses. inst_valid is never high for two consecutive cycles.
- Programming has priority over fetch:
  - prog_en=1 in IDLE blocks acceptance of fetch_req.
  - prog_en=1 in READ aborts the fetch: state<=IDLE, no inst_valid, inst unchanged, and the write still happens.
- fetch_req while in READ is ignored. The requester must hold req until fetch_ready.
- Wrap: if fetch_pc = 2**ADDR_W-1 and INST_BYTES=2, the LSB comes from address 0.
- rst asserted mid-READ: immediate return to IDLE, inst=0, no valid pulse.

Test Plan:
- Program bytes F0,0F,F4,01 after prog_start; fetch_pc=0 then 2 -> inst=16'hF00F, then inst=16'hF401. Each inst_valid pulse is 2 cycles after acceptance; prog_ptr=4 after the writes.
- Wrap: program mem[255]=AB and mem[0]=CD; fetch_pc=255 -> inst=16'hABCD. Writing 257 bytes leaves prog_ptr=1.
- Abort: accept a fetch, then assert prog_en on the next cycle -> no inst_valid, inst keeps its previous value. A retry after prog_en drops returns the new data.
- Back-to-back: hold fetch_req with pc 0,2,4 -> three valid pulses, 3 cycles apart, and fetch_ready=0 while in READ.
- Reset: assert rst mid-READ -> inst=0, inst_valid=0, prog_ptr=0 immediately. A fetch after reset returns the pre-reset memory contents.
- Parameter sweep ADDR_W=4, INST_BYTES=3: program 01,02,03 -> inst=24'h010203 with latency 3; fetch_pc=15 reads bytes 15, 0, 1.

Source files
------------

// File: rtl/inst_mem_prog.sv
// Byte-addressed instruction store with a byte-stream programming port and a
// req/ready/valid fetch port that assembles INST_BYTES bytes MSB-first, one per cycle.
module inst_mem_prog #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INST_BYTES = 2,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_start,
  input  logic                    prog_en,
  input  logic [7:0]              prog_data,
  output logic [ADDR_W-1:0]       prog_ptr,
  input  logic                    fetch_req,
  input  logic [ADDR_W-1:0]       fetch_pc,
  output logic                    fetch_ready,
  output logic                    inst_valid,
  output logic [8*INST_BYTES-1:0] inst
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned InstW = 8 * INST_BYTES;
  localparam int unsigned KW    = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam logic [KW-1:0] LastK = KW'(INST_BYTES - 1);
  localparam logic [7:0] InitByte = INIT_ZERO ? 8'h00 : 8'hxx;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [KW-1:0]       k_q, k_d;
  logic [InstW-1:0]    shift_q, shift_d;
  logic [InstW-1:0]    inst_q, inst_d;
  logic                valid_q, valid_d;

  // Power-up contents come from the declaration; rst never touches the array.
  logic [7:0]          mem_q [Depth] = '{default: InitByte};

  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_byte;
  logic [InstW-1:0]    shifted;

  assign wr_addr = prog_start ? '0 : ptr_q;
  assign rd_addr = addr_q + ADDR_W'(k_q);
  assign rd_byte = mem_q[rd_addr];
  // Truncation drops the oldest byte; works for INST_BYTES == 1 too.
  assign shifted = InstW'({shift_q, rd_byte});

  always_ff @(posedge clk) begin
    if (prog_en) begin
      mem_q[wr_addr] <= prog_data;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (prog_en) begin
      ptr_d = wr_addr + ADDR_W'(1);
    end else if (prog_start) begin
      ptr_d = '0;
    end
  end

  assign fetch_ready = (state_q == StIdle) & ~prog_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    shift_d = shift_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_req && fetch_ready) begin
          addr_d  = fetch_pc;
          k_d     = '0;
          shift_d = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (prog_en) begin
          // A write during assembly could tear the instruction, so abandon it.
          state_d = StIdle;
        end else begin
          shift_d = shifted;
          k_d     = k_q + 1'b1;
          if (k_q == LastK) begin
            inst_d  = shifted;
            valid_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      k_q     <= '0;
      shift_q <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      shift_q <= shift_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign prog_ptr   = ptr_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_inst_mem_prog.sv
// Directed bench for inst_mem_prog: default 8-bit/2-byte instance plus a 4-bit/3-byte instance.
module tb_inst_mem_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, s0, e0, req0, rdy0, vld0;
  logic [7:0]  d0, ptr0, pc0;
  logic [15:0] inst0;

  logic        rst1, s1, e1, req1, rdy1, vld1;
  logic [7:0]  d1;
  logic [3:0]  ptr1, pc1;
  logic [23:0] inst1;

  inst_mem_prog #(.ADDR_W(8), .INST_BYTES(2), .INIT_ZERO(1'b1)) u_dut0 (
    .clk(clk), .rst(rst0), .prog_start(s0), .prog_en(e0), .prog_data(d0), .prog_ptr(ptr0),
    .fetch_req(req0), .fetch_pc(pc0), .fetch_ready(rdy0), .inst_valid(vld0), .inst(inst0)
  );

  inst_mem_prog #(.ADDR_W(4), .INST_BYTES(3), .INIT_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst(rst1), .prog_start(s1), .prog_en(e1), .prog_data(d1), .prog_ptr(ptr1),
    .fetch_req(req1), .fetch_pc(pc1), .fetch_ready(rdy1), .inst_valid(vld1), .inst(inst1)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic rdy(input bit s);
    return s ? rdy1 : rdy0;
  endfunction

  function automatic logic vld(input bit s);
    return s ? vld1 : vld0;
  endfunction

  function automatic logic [31:0] instv(input bit s);
    return s ? 32'(inst1) : 32'(inst0);
  endfunction

  task automatic set_prog(input bit s, input logic st, input logic en, input logic [7:0] d);
    if (s) begin s1 = st; e1 = en; d1 = d; end
    else   begin s0 = st; e0 = en; d0 = d; end
  endtask

  task automatic set_fetch(input bit s, input logic req, input logic [7:0] pc);
    if (s) begin req1 = req; pc1 = pc[3:0]; end
    else   begin req0 = req; pc0 = pc; end
  endtask

  // One-cycle programming pulse; starts and ends at posedge+1.
  task automatic prog(input bit s, input logic st, input logic en, input logic [7:0] d);
    set_prog(s, st, en, d);
    @(posedge clk); #1;
    set_prog(s, 1'b0, 1'b0, 8'h00);
  endtask

  // Latency = edges from the accepting edge to the cycle where inst_valid is seen.
  task automatic do_fetch(input bit s, input logic [7:0] pc, output logic [31:0] data,
                          output int lat);
    bit ok;
    ok   = 1'b0;
    lat  = 0;
    data = '0;
    set_fetch(s, 1'b1, pc);
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (rdy(s)) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check("fetch_accept_timeout", 32'd0, 32'd1);
      set_fetch(s, 1'b0, pc);
    end else begin
      @(posedge clk); #1;
      set_fetch(s, 1'b0, pc);
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); @(negedge clk);
        if (vld(s)) begin lat = c; data = instv(s); break; end
      end
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] got;
  int          lat;
  logic [7:0]  bpcs[3];
  logic [15:0] bexp[3];
  int          bidx, vi;
  logic        r, v;

  initial begin
    vecs[0] = '{8'h00, 16'hF00F};
    vecs[1] = '{8'h02, 16'hF401};
    vecs[2] = '{8'h01, 16'h0FF4};
    vecs[3] = '{8'h04, 16'h1234};
    vecs[4] = '{8'h06, 16'h5678};
    vecs[5] = '{8'h03, 16'h0112};
    vecs[6] = '{8'h07, 16'h7800};
    vecs[7] = '{8'h08, 16'h0000};
    bpcs[0] = 8'h00; bpcs[1] = 8'h02; bpcs[2] = 8'h04;
    bexp[0] = 16'hCD5A; bexp[1] = 16'h0203; bexp[2] = 16'h0405;

    rst0 = 1'b1; rst1 = 1'b1;
    set_prog(0, 0, 0, 8'h00); set_fetch(0, 0, 8'h00);
    set_prog(1, 0, 0, 8'h00); set_fetch(1, 0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst", 32'(inst0), 32'h0);
    check("rst_valid", 32'(vld0), 32'h0);
    check("rst_ptr", 32'(ptr0), 32'h0);
    check("rst_ready", 32'(rdy0), 32'h1);
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // Basic programming and table-driven fetches.
    prog(0, 1, 0, 8'h00);
    prog(0, 0, 1, 8'hF0); prog(0, 0, 1, 8'h0F); prog(0, 0, 1, 8'hF4); prog(0, 0, 1, 8'h01);
    check("ptr_after_4", 32'(ptr0), 32'd4);
    prog(0, 0, 1, 8'h12); prog(0, 0, 1, 8'h34); prog(0, 0, 1, 8'h56); prog(0, 0, 1, 8'h78);
    check("ptr_after_8", 32'(ptr0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      do_fetch(0, vecs[i].pc, got, lat);
      check($sformatf("vec%0d_inst", i), got, 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end

    // Pointer wrap over 257 writes, then a fetch straddling the top address.
    prog(0, 1, 0, 8'h00);
    for (int i = 0; i < 257; i++) begin
      prog(0, 0, 1, (i == 255) ? 8'hAB : (i == 256) ? 8'hCD : 8'(i));
    end
    check("wrap_ptr", 32'(ptr0), 32'd1);
    do_fetch(0, 8'hFF, got, lat);
    check("wrap_inst", got, 32'h0000ABCD);
    do_fetch(0, 8'h00, got, lat);
    check("pre_abort_inst", got, 32'h0000CD01);

    // Abort: prog_en the cycle after acceptance writes mem[1] and drops the fetch.
    set_fetch(0, 1, 8'h00);
    @(negedge clk);
    check("abort_accept_ready", 32'(rdy0), 32'h1);
    @(posedge clk); #1;
    set_fetch(0, 0, 8'h00);
    set_prog(0, 0, 1, 8'h5A);
    @(negedge clk);
    check("abort_ready_in_read", 32'(rdy0), 32'h0);
    @(posedge clk); #1;
    set_prog(0, 0, 0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort_novalid%0d", c), 32'(vld0), 32'h0);
      check($sformatf("abort_hold%0d", c), 32'(inst0), 32'h0000CD01);
      @(posedge clk); #1;
    end
    check("abort_ptr", 32'(ptr0), 32'd2);
    do_fetch(0, 8'h00, got, lat);
    check("retry_inst", got, 32'h0000CD5A);
    check("retry_lat", 32'(lat), 32'd2);

    // prog_en in IDLE blocks acceptance.
    set_prog(0, 0, 1, 8'h02);
    set_fetch(0, 1, 8'h02);
    @(negedge clk);
    check("block_ready", 32'(rdy0), 32'h0);
    @(posedge clk); #1;
    set_prog(0, 0, 0, 8'h00);
    set_fetch(0, 0, 8'h02);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("block_idle%0d", c), 32'({rdy0, vld0}), 32'b10);
      @(posedge clk); #1;
    end
    check("block_ptr", 32'(ptr0), 32'd3);

    // Back-to-back with fetch_req held: accept at cycles 0,3,6; valid at 3,6,9.
    bidx = 0; vi = 0;
    set_fetch(0, 1, bpcs[0]);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      r = rdy0; v = vld0;
      check($sformatf("b2b_ready_c%0d", cyc), 32'(r), 32'((cyc % 3 == 0) || (cyc >= 9)));
      check($sformatf("b2b_valid_c%0d", cyc), 32'(v),
            32'((cyc == 3) || (cyc == 6) || (cyc == 9)));
      if (v && vi < 3) begin
        check($sformatf("b2b_inst%0d", vi), 32'(inst0), 32'(bexp[vi]));
        vi++;
      end
      @(posedge clk); #1;
      if (r && req0) begin
        bidx++;
        if (bidx < 3) set_fetch(0, 1, bpcs[bidx]);
        else set_fetch(0, 0, 8'h00);
      end
    end
    check("b2b_count", 32'(vi), 32'd3);

    // Asynchronous reset in the middle of READ.
    set_fetch(0, 1, 8'h04);
    @(negedge clk);
    @(posedge clk); #1;
    set_fetch(0, 0, 8'h00);
    #2 rst0 = 1'b1;
    #1;
    check("midrst_inst", 32'(inst0), 32'h0);
    check("midrst_valid", 32'(vld0), 32'h0);
    check("midrst_ptr", 32'(ptr0), 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("postrst_novalid%0d", c), 32'(vld0), 32'h0);
    end
    @(posedge clk); #1;
    do_fetch(0, 8'h02, got, lat);
    check("postrst_inst_a", got, 32'h00000203);
    do_fetch(0, 8'h00, got, lat);
    check("postrst_inst_b", got, 32'h0000CD5A);

    // Parameter sweep instance: ADDR_W=4, INST_BYTES=3.
    prog(1, 1, 0, 8'h00);
    prog(1, 0, 1, 8'h01); prog(1, 0, 1, 8'h02); prog(1, 0, 1, 8'h03);
    check("p1_ptr3", 32'(ptr1), 32'd3);
    do_fetch(1, 8'h00, got, lat);
    check("p1_inst", got, 32'h00010203);
    check("p1_lat", 32'(lat), 32'd3);
    for (int a = 3; a < 16; a++) begin
      prog(1, 0, 1, (a == 15) ? 8'hF1 : 8'(8'h30 + a));
    end
    check("p1_ptr_wrap", 32'(ptr1), 32'd0);
    do_fetch(1, 8'h0F, got, lat);
    check("p1_wrap_inst", got, 32'h00F10102);
    check("p1_wrap_lat", 32'(lat), 32'd3);
    do_fetch(1, 8'h01, got, lat);
    check("p1_inst_1", got, 32'h00020333);
    // prog_start with prog_en in the same cycle writes address 0.
    prog(1, 0, 1, 8'h77);
    prog(1, 1, 1, 8'hEE);
    check("p1_start_en_ptr", 32'(ptr1), 32'd1);
    do_fetch(1, 8'h0F, got, lat);
    check("p1_start_en_inst", got, 32'h00F1EE02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
